// File: rtl/video_frame_checker.sv
// Video stream frame checker: counts DE-qualified pixels, checks line and
// frame geometry, and produces a per-frame modular checksum.
module video_frame_checker #(
  parameter int H_DISP   = 180,
  parameter int V_DISP   = 180,
  parameter int DATA_W   = 8,
  parameter int CH_NUM   = 1,
  parameter int CKS_W    = 24,
  parameter int N_FRAMES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vid_vsync,
  input  logic                     vid_de,
  input  logic [DATA_W*CH_NUM-1:0] vid_data,
  output logic                     frame_done,
  output logic [CKS_W-1:0]         frame_cks,
  output logic [15:0]              frame_cnt,
  output logic [31:0]              pix_cnt,
  output logic                     err_hlen,
  output logic                     err_vlen,
  output logic                     capture_done
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t             state_q, state_d;
  logic               vs_q, de_q;
  logic [31:0]        x_cnt_q, x_cnt_d;
  logic [31:0]        y_cnt_q, y_cnt_d;
  logic [31:0]        pix_cnt_q, pix_cnt_d;
  logic [CKS_W-1:0]   acc_q, acc_d;
  logic [CKS_W-1:0]   frame_cks_q, frame_cks_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               frame_done_q, frame_done_d;
  logic               err_hlen_q, err_hlen_d;
  logic               err_vlen_q, err_vlen_d;
  logic               capture_done_q, capture_done_d;

  logic               vs_rise, de_fall, frame_end, restart;
  logic [CKS_W-1:0]   px_sum;

  always_comb begin
    state_d        = state_q;
    x_cnt_d        = x_cnt_q;
    y_cnt_d        = y_cnt_q;
    pix_cnt_d      = pix_cnt_q;
    acc_d          = acc_q;
    frame_cks_d    = frame_cks_q;
    frame_cnt_d    = frame_cnt_q;
    frame_done_d   = 1'b0;
    err_hlen_d     = err_hlen_q;
    err_vlen_d     = err_vlen_q;
    capture_done_d = capture_done_q;
    frame_end      = 1'b0;
    restart        = 1'b0;

    vs_rise = vid_vsync & ~vs_q;
    de_fall = ~vid_de & de_q;

    px_sum = '0;
    for (int unsigned ch = 0; ch < CH_NUM; ch++) begin
      px_sum = px_sum + CKS_W'(vid_data[ch*DATA_W +: DATA_W]);
    end

    case (state_q)
      IDLE: begin
        if (vs_rise) begin
          state_d = ACTIVE;
          restart = 1'b1;
        end
      end
      ACTIVE: begin
        // Line-end check runs before the vsync check so a coincident vs_rise
        // sees the post-increment line count.
        if (de_fall) begin
          if (x_cnt_q != 32'(H_DISP)) err_hlen_d = 1'b1;
          x_cnt_d = '0;
          y_cnt_d = y_cnt_q + 32'd1;
          if (y_cnt_q == 32'(V_DISP - 1)) frame_end = 1'b1;
        end
        if (frame_end) begin
          frame_done_d = 1'b1;
          frame_cks_d  = acc_q;
          frame_cnt_d  = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
          acc_d        = '0;
          y_cnt_d      = '0;
          pix_cnt_d    = '0;
          if (N_FRAMES != 0 && frame_cnt_d == 16'(N_FRAMES)) begin
            state_d        = DONE;
            capture_done_d = 1'b1;
          end else if (vs_rise) begin
            restart = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (vs_rise) begin
          err_vlen_d = 1'b1;
          restart    = 1'b1;
        end
      end
      default: ;
    endcase

    if (restart) begin
      x_cnt_d   = '0;
      y_cnt_d   = '0;
      pix_cnt_d = '0;
      acc_d     = '0;
    end

    // A pixel coinciding with vs_rise is the first pixel of the new frame.
    if (state_d == ACTIVE && vid_de) begin
      x_cnt_d   = x_cnt_d + 32'd1;
      pix_cnt_d = pix_cnt_d + 32'd1;
      acc_d     = acc_d + px_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      vs_q           <= 1'b0;
      de_q           <= 1'b0;
      x_cnt_q        <= '0;
      y_cnt_q        <= '0;
      pix_cnt_q      <= '0;
      acc_q          <= '0;
      frame_cks_q    <= '0;
      frame_cnt_q    <= '0;
      frame_done_q   <= 1'b0;
      err_hlen_q     <= 1'b0;
      err_vlen_q     <= 1'b0;
      capture_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      vs_q           <= vid_vsync;
      de_q           <= vid_de;
      x_cnt_q        <= x_cnt_d;
      y_cnt_q        <= y_cnt_d;
      pix_cnt_q      <= pix_cnt_d;
      acc_q          <= acc_d;
      frame_cks_q    <= frame_cks_d;
      frame_cnt_q    <= frame_cnt_d;
      frame_done_q   <= frame_done_d;
      err_hlen_q     <= err_hlen_d;
      err_vlen_q     <= err_vlen_d;
      capture_done_q <= capture_done_d;
    end
  end

  assign frame_done   = frame_done_q;
  assign frame_cks    = frame_cks_q;
  assign frame_cnt    = frame_cnt_q;
  assign pix_cnt      = pix_cnt_q;
  assign err_hlen     = err_hlen_q;
  assign err_vlen     = err_vlen_q;
  assign capture_done = capture_done_q;

endmodule

// File: tb/tb_video_frame_checker.sv
// Bench for video_frame_checker: four configurations share one stimulus
// stream and are checked each cycle against a frame-level reference model.
module tb_video_frame_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vid_vsync = 1'b0;
  logic        vid_de = 1'b0;
  logic [23:0] vid_data = '0;

  logic [3:0]  fd, eh, ev, cap;
  logic [23:0] cks0, cks1, cks3;
  logic [7:0]  cks2;
  logic [15:0] fcnt0, fcnt1, fcnt2, fcnt3;
  logic [31:0] pix0, pix1, pix2, pix3;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;
  int fd0_pulses = 0;

  always #5 clk = ~clk;

  // u0: grey, 24-bit checksum, free running
  video_frame_checker #(.H_DISP(4), .V_DISP(3), .DATA_W(8), .CH_NUM(1), .CKS_W(24), .N_FRAMES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .vid_vsync(vid_vsync), .vid_de(vid_de), .vid_data(vid_data[7:0]),
    .frame_done(fd[0]), .frame_cks(cks0), .frame_cnt(fcnt0), .pix_cnt(pix0),
    .err_hlen(eh[0]), .err_vlen(ev[0]), .capture_done(cap[0]));
  // u1: RGB
  video_frame_checker #(.H_DISP(4), .V_DISP(3), .DATA_W(8), .CH_NUM(3), .CKS_W(24), .N_FRAMES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .vid_vsync(vid_vsync), .vid_de(vid_de), .vid_data(vid_data),
    .frame_done(fd[1]), .frame_cks(cks1), .frame_cnt(fcnt1), .pix_cnt(pix1),
    .err_hlen(eh[1]), .err_vlen(ev[1]), .capture_done(cap[1]));
  // u2: 8-bit checksum to exercise wrap-around
  video_frame_checker #(.H_DISP(4), .V_DISP(3), .DATA_W(8), .CH_NUM(1), .CKS_W(8), .N_FRAMES(0)) u2 (
    .clk(clk), .rst_n(rst_n), .vid_vsync(vid_vsync), .vid_de(vid_de), .vid_data(vid_data[7:0]),
    .frame_done(fd[2]), .frame_cks(cks2), .frame_cnt(fcnt2), .pix_cnt(pix2),
    .err_hlen(eh[2]), .err_vlen(ev[2]), .capture_done(cap[2]));
  // u3: stops after two frames
  video_frame_checker #(.H_DISP(4), .V_DISP(3), .DATA_W(8), .CH_NUM(1), .CKS_W(24), .N_FRAMES(2)) u3 (
    .clk(clk), .rst_n(rst_n), .vid_vsync(vid_vsync), .vid_de(vid_de), .vid_data(vid_data[7:0]),
    .frame_done(fd[3]), .frame_cks(cks3), .frame_cnt(fcnt3), .pix_cnt(pix3),
    .err_hlen(eh[3]), .err_vlen(ev[3]), .capture_done(cap[3]));

  // Reference model: frame bookkeeping per configuration.
  localparam int H = 4;
  localparam int V = 3;
  bit      m_in_frame [4];
  bit      m_stopped  [4];
  bit      m_fd [4], m_eh [4], m_ev [4];
  longint  m_x [4], m_lines [4], m_pix [4], m_sum [4], m_cks [4], m_cnt [4];
  bit      m_pvs, m_pde;

  function automatic longint modulus(int k);
    return (k == 2) ? 64'd256 : 64'd16777216;
  endfunction

  function automatic longint pixel_value(int k, logic [23:0] d);
    if (k == 1) return longint'(d[7:0]) + longint'(d[15:8]) + longint'(d[23:16]);
    return longint'(d[7:0]);
  endfunction

  function automatic int frames_wanted(int k);
    return (k == 3) ? 2 : 0;
  endfunction

  always @(posedge clk) begin
    bit rise, fall;
    rise = vid_vsync && !m_pvs;
    fall = !vid_de && m_pde;
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        m_in_frame[k] = 0; m_stopped[k] = 0; m_fd[k] = 0; m_eh[k] = 0; m_ev[k] = 0;
        m_x[k] = 0; m_lines[k] = 0; m_pix[k] = 0; m_sum[k] = 0; m_cks[k] = 0; m_cnt[k] = 0;
      end else begin
        m_fd[k] = 0;
        if (!m_stopped[k]) begin
          if (m_in_frame[k] && fall) begin
            if (m_x[k] != H) m_eh[k] = 1;
            m_x[k] = 0;
            m_lines[k] = m_lines[k] + 1;
            if (m_lines[k] == V) begin
              m_fd[k] = 1;
              m_cks[k] = m_sum[k];
              if (m_cnt[k] < 65535) m_cnt[k] = m_cnt[k] + 1;
              m_in_frame[k] = 0; m_lines[k] = 0; m_pix[k] = 0; m_sum[k] = 0;
              if (frames_wanted(k) != 0 && m_cnt[k] == frames_wanted(k)) m_stopped[k] = 1;
            end
          end
          if (!m_stopped[k] && rise) begin
            if (m_in_frame[k]) m_ev[k] = 1;
            m_in_frame[k] = 1; m_x[k] = 0; m_lines[k] = 0; m_pix[k] = 0; m_sum[k] = 0;
          end
          if (!m_stopped[k] && m_in_frame[k] && vid_de) begin
            m_x[k] = m_x[k] + 1;
            m_pix[k] = m_pix[k] + 1;
            m_sum[k] = (m_sum[k] + pixel_value(k, vid_data)) % modulus(k);
          end
        end
      end
    end
    m_pvs = rst_n ? vid_vsync : 1'b0;
    m_pde = rst_n ? vid_de : 1'b0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [23:0] a_cks [4];
      logic [15:0] a_cnt [4];
      logic [31:0] a_pix [4];
      a_cks[0] = cks0; a_cks[1] = cks1; a_cks[2] = {16'h0, cks2}; a_cks[3] = cks3;
      a_cnt[0] = fcnt0; a_cnt[1] = fcnt1; a_cnt[2] = fcnt2; a_cnt[3] = fcnt3;
      a_pix[0] = pix0; a_pix[1] = pix1; a_pix[2] = pix2; a_pix[3] = pix3;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("u%0d.frame_done", k), 64'(fd[k]), 64'(m_fd[k]));
        chk($sformatf("u%0d.frame_cks", k), 64'(a_cks[k]), 64'(m_cks[k]));
        chk($sformatf("u%0d.frame_cnt", k), 64'(a_cnt[k]), 64'(m_cnt[k]));
        chk($sformatf("u%0d.pix_cnt", k), 64'(a_pix[k]), 64'(m_pix[k]));
        chk($sformatf("u%0d.err_hlen", k), 64'(eh[k]), 64'(m_eh[k]));
        chk($sformatf("u%0d.err_vlen", k), 64'(ev[k]), 64'(m_ev[k]));
        chk($sformatf("u%0d.capture_done", k), 64'(cap[k]), 64'(m_stopped[k]));
      end
    end
  end

  always @(posedge clk) if (rst_n && fd[0] === 1'b1) fd0_pulses++;

  task automatic tick(input bit vs, input bit de, input logic [23:0] d);
    @(negedge clk);
    vid_vsync = vs;
    vid_de    = de;
    vid_data  = d;
  endtask

  task automatic vsync_pulse();
    tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
  endtask

  task automatic line(input int n, input int base, input int gap);
    for (int i = 1; i <= n; i++) tick(0, 1, 24'(base + i));
    for (int i = 0; i < gap; i++) tick(0, 0, 0);
  endtask

  initial begin
    tick(0, 0, 0); tick(0, 0, 0);
    cmp_en = 1'b1;
    tick(0, 0, 0);
    chk("reset.pix_cnt", 64'(pix0), 64'd0);
    chk("reset.frame_cks", 64'(cks0), 64'd0);
    rst_n = 1'b1;
    tick(0, 0, 0);

    // Clean frame 1..12; check frame_done lands one cycle after the last de_fall
    vsync_pulse();
    line(4, 0, 2); line(4, 4, 2); line(4, 8, 0);
    tick(0, 0, 0);
    chk("f1.done_early", 64'(fd[0]), 64'd0);
    tick(0, 0, 0);
    chk("f1.done_pulse", 64'(fd[0]), 64'd1);
    tick(0, 0, 0);
    chk("f1.done_single", 64'(fd[0]), 64'd0);
    chk("f1.cks", 64'(cks0), 64'd78);
    chk("f1.cnt", 64'(fcnt0), 64'd1);
    chk("f1.err_hlen", 64'(eh[0]), 64'd0);
    chk("f1.err_vlen", 64'(ev[0]), 64'd0);
    chk("f1.u3_capture", 64'(cap[3]), 64'd0);

    // Short second line
    vsync_pulse();
    line(4, 0, 2); line(3, 4, 2); line(4, 7, 3);
    chk("f2.cks", 64'(cks0), 64'd66);
    chk("f2.err_hlen", 64'(eh[0]), 64'd1);
    chk("f2.err_vlen", 64'(ev[0]), 64'd0);
    chk("f2.u3_capture", 64'(cap[3]), 64'd1);
    chk("f2.u3_cnt", 64'(fcnt3), 64'd2);

    // Partial frame cut by vsync, then a clean frame
    vsync_pulse();
    line(4, 0, 2); line(4, 4, 2);
    vsync_pulse();
    line(4, 0, 2); line(4, 4, 2); line(4, 8, 3);
    chk("f4.err_vlen", 64'(ev[0]), 64'd1);
    chk("f4.cks", 64'(cks0), 64'd78);
    chk("f4.cnt", 64'(fcnt0), 64'd3);
    chk("f4.pulses", 64'(fd0_pulses), 64'd3);

    // RGB pixels {02,01,FF}
    vsync_pulse();
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 4; i++) tick(0, 1, 24'h0201FF);
      tick(0, 0, 0); tick(0, 0, 0);
    end
    tick(0, 0, 0);
    chk("f5.rgb_cks", 64'(cks1), 64'd3096);
    chk("f5.wrap_cks", 64'(cks2), 64'hF4);
    chk("f5.grey_cks", 64'(cks0), 64'd3060);
    chk("f5.u3_frozen", 64'(fcnt3), 64'd2);

    // Reset mid-frame, then stray DE before any vsync
    vsync_pulse();
    line(4, 0, 2);
    tick(0, 1, 5); tick(0, 1, 6);
    rst_n = 1'b0;
    tick(0, 1, 7); tick(0, 1, 8);
    rst_n = 1'b1;
    tick(0, 0, 0); tick(0, 0, 0);
    line(4, 20, 2);
    chk("rst.u3_capture", 64'(cap[3]), 64'd0);
    chk("rst.u3_cnt", 64'(fcnt3), 64'd0);
    chk("rst.pix_cnt", 64'(pix3), 64'd0);
    chk("rst.err_hlen", 64'(eh[0]), 64'd0);
    chk("rst.cks", 64'(cks0), 64'd0);

    vsync_pulse();
    line(4, 0, 2); line(4, 4, 2); line(4, 8, 3);
    chk("f7.u3_cks", 64'(cks3), 64'd78);
    chk("f7.u3_cnt", 64'(fcnt3), 64'd1);
    tick(0, 0, 0);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
